// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite channel bundle shared by the arbiter's two upstream masters and its downstream slave.
// Every channel transfers on a rising aclk where valid & ready; valid never waits on ready and, once high, holds with stable payload until that transfer.
interface axi_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-to-one AXI4-Lite arbiter: one transaction in flight, the granted master is locked onto
// m_axi until its R or B handshake, and every other upstream output is held quiet meanwhile.
module axi_lite_arbiter_2to1 #(
  parameter bit RR_EN    = 1'b1,
  parameter bit RD_FIRST = 1'b1
) (
  input  logic         aclk,
  input  logic         areset_n,
  axi_lite_if.slave    s0_axi,
  axi_lite_if.slave    s1_axi,
  axi_lite_if.master   m_axi,
  output logic         owner_o,
  output logic         busy_o,
  output logic [1:0]   state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  // rr_q is the side that wins the next tie; it always points away from the latest winner.
  logic   rr_q, rr_d;
  logic   win;
  logic   pick_rd;
  logic   fwd_rd, fwd_wr;
  logic [1:0] req_ar, req_aw, req;

  assign req_ar = {s1_axi.arvalid, s0_axi.arvalid};
  assign req_aw = {s1_axi.awvalid, s0_axi.awvalid};
  assign req    = req_ar | req_aw;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    win     = 1'b0;
    pick_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) win = RR_EN ? rr_q : 1'b0;
          else              win = req[1];
          pick_rd = req_ar[win] & (~req_aw[win] | RD_FIRST);
          state_d = pick_rd ? RD : WR;
          owner_d = win;
          rr_d    = ~win;
        end
      end
      RD:      if (m_axi.rvalid && m_axi.rready) state_d = IDLE;
      WR:      if (m_axi.bvalid && m_axi.bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating on areset_n keeps every handshake quiet in the reset cycle itself, not just after it.
  assign fwd_rd = areset_n && (state_q == RD);
  assign fwd_wr = areset_n && (state_q == WR);

  always_comb begin
    m_axi.araddr   = '0;
    m_axi.arvalid  = 1'b0;
    m_axi.rready   = 1'b0;
    m_axi.awaddr   = '0;
    m_axi.awvalid  = 1'b0;
    m_axi.wdata    = '0;
    m_axi.wstrb    = '0;
    m_axi.wvalid   = 1'b0;
    m_axi.bready   = 1'b0;
    s0_axi.arready = 1'b0;
    s0_axi.rdata   = '0;
    s0_axi.rresp   = 2'b00;
    s0_axi.rvalid  = 1'b0;
    s0_axi.awready = 1'b0;
    s0_axi.wready  = 1'b0;
    s0_axi.bresp   = 2'b00;
    s0_axi.bvalid  = 1'b0;
    s1_axi.arready = 1'b0;
    s1_axi.rdata   = '0;
    s1_axi.rresp   = 2'b00;
    s1_axi.rvalid  = 1'b0;
    s1_axi.awready = 1'b0;
    s1_axi.wready  = 1'b0;
    s1_axi.bresp   = 2'b00;
    s1_axi.bvalid  = 1'b0;
    if (fwd_rd) begin
      m_axi.araddr  = owner_q ? s1_axi.araddr  : s0_axi.araddr;
      m_axi.arvalid = owner_q ? s1_axi.arvalid : s0_axi.arvalid;
      m_axi.rready  = owner_q ? s1_axi.rready  : s0_axi.rready;
      if (owner_q) begin
        s1_axi.arready = m_axi.arready;
        s1_axi.rdata   = m_axi.rdata;
        s1_axi.rresp   = m_axi.rresp;
        s1_axi.rvalid  = m_axi.rvalid;
      end else begin
        s0_axi.arready = m_axi.arready;
        s0_axi.rdata   = m_axi.rdata;
        s0_axi.rresp   = m_axi.rresp;
        s0_axi.rvalid  = m_axi.rvalid;
      end
    end
    if (fwd_wr) begin
      m_axi.awaddr  = owner_q ? s1_axi.awaddr  : s0_axi.awaddr;
      m_axi.awvalid = owner_q ? s1_axi.awvalid : s0_axi.awvalid;
      m_axi.wdata   = owner_q ? s1_axi.wdata   : s0_axi.wdata;
      m_axi.wstrb   = owner_q ? s1_axi.wstrb   : s0_axi.wstrb;
      m_axi.wvalid  = owner_q ? s1_axi.wvalid  : s0_axi.wvalid;
      m_axi.bready  = owner_q ? s1_axi.bready  : s0_axi.bready;
      if (owner_q) begin
        s1_axi.awready = m_axi.awready;
        s1_axi.wready  = m_axi.wready;
        s1_axi.bresp   = m_axi.bresp;
        s1_axi.bvalid  = m_axi.bvalid;
      end else begin
        s0_axi.awready = m_axi.awready;
        s0_axi.wready  = m_axi.wready;
        s0_axi.bresp   = m_axi.bresp;
        s0_axi.bvalid  = m_axi.bvalid;
      end
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;
endmodule
